ram_frame_row_buf: RTL and testbench

- Parametrised single-clock two-port frame-row buffer for intra prediction.
- Holds the bottom reconstructed pixel row of each LCU, to be read back as top neighbours for the next LCU row.
- Successor to the fixed 32x480 row RAM model; adds:
  - generic width and depth,
  - a byte-lane write mask,
  - write-first read/write collision bypass,
  - a self-clearing initialisation sequencer,
  - out-of-range address detection.
- Port A is write-only; port B is read-only.

---
 rtl/ram_frame_row_buf.sv | 97 +++++++++
 tb/tb_ram_frame_row_buf.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ram_frame_row_buf.sv
// ram_frame_row_buf: two-port frame-row buffer (write port A, registered read port B)
// with byte-lane writes, write-first collision bypass, self-clearing init and range checks.
module ram_frame_row_buf #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH = 480,
    parameter logic [WORD_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    output logic                    init_done_o,
    input  logic                    cena_i,
    input  logic                    wena_i,
    input  logic [WORD_WIDTH/8-1:0] bea_i,
    input  logic [ADDR_WIDTH-1:0]   addra_i,
    input  logic [WORD_WIDTH-1:0]   dataa_i,
    input  logic                    cenb_i,
    input  logic [ADDR_WIDTH-1:0]   addrb_i,
    output logic [WORD_WIDTH-1:0]   datab_o,
    output logic                    datab_vld_o,
    output logic                    addr_err_o
);
    localparam int NB = WORD_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    typedef enum logic {INIT, READY} state_t;
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_datab;
    logic                  r_datab_vld;
    logic                  r_init_done;
    logic                  r_addr_err;
    logic                  w_ready;
    logic                  w_a_inr;
    logic                  w_b_inr;
    logic                  w_wr_req;
    logic                  w_wr;
    logic                  w_rd_req;
    logic                  w_err;
    logic [WORD_WIDTH-1:0] w_mask;
    logic [WORD_WIDTH-1:0] w_rd_word;
    logic [WORD_WIDTH-1:0] w_fwd;
    genvar i;
    for (i = 0; i < NB; i++) begin : g_mask
        assign w_mask[8*i +: 8] = {8{bea_i[i]}};
    end
    assign w_ready   = (r_state == READY);
    assign w_a_inr   = {1'b0, addra_i} < LP_DEPTH;
    assign w_b_inr   = {1'b0, addrb_i} < LP_DEPTH;
    assign w_wr_req  = w_ready & ~cena_i & ~wena_i;
    assign w_wr      = w_wr_req & w_a_inr;
    assign w_rd_req  = w_ready & ~cenb_i;
    assign w_err     = (w_wr_req & ~w_a_inr) | (w_rd_req & ~w_b_inr);
    assign w_rd_word = r_mem[addrb_i];
    // write-first: lanes being written this cycle bypass the array
    assign w_fwd = (w_wr && addra_i == addrb_i) ? ((dataa_i & w_mask) | (w_rd_word & ~w_mask)) : w_rd_word;
    always_ff @(posedge clk) begin
        if (!w_ready)
            r_mem[r_clr_cnt] <= INIT_VALUE;
        else if (w_wr)
            r_mem[addra_i] <= (r_mem[addra_i] & ~w_mask) | (dataa_i & w_mask);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_clr_cnt   <= '0;
            r_datab     <= '0;
            r_datab_vld <= 1'b0;
            r_init_done <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_datab_vld <= w_rd_req;
            if (w_rd_req)
                r_datab <= w_b_inr ? w_fwd : INIT_VALUE;
            if (clr_i) begin
                r_state     <= INIT;
                r_clr_cnt   <= '0;
                r_init_done <= 1'b0;
                r_addr_err  <= 1'b0;
            end else if (!w_ready) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
                if (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    r_state     <= READY;
                    r_clr_cnt   <= '0;
                    r_init_done <= 1'b1;
                end
            end else if (w_err) begin
                r_addr_err <= 1'b1;
            end
        end
    end
    assign datab_o     = r_datab;
    assign datab_vld_o = r_datab_vld;
    assign init_done_o = r_init_done;
    assign addr_err_o  = r_addr_err;
endmodule

// File: tb/tb_ram_frame_row_buf.sv
// tb_ram_frame_row_buf: directed scoreboard bench for ram_frame_row_buf (32-bit, 480 deep).
module tb_ram_frame_row_buf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_i;
    logic        init_done_o;
    logic        cena_i;
    logic        wena_i;
    logic [3:0]  bea_i;
    logic [8:0]  addra_i;
    logic [31:0] dataa_i;
    logic        cenb_i;
    logic [8:0]  addrb_i;
    logic [31:0] datab_o;
    logic        datab_vld_o;
    logic        addr_err_o;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mdl [480];
    logic [31:0] exp_q [$];
    logic [31:0] last_d;
    int          left;
    bit          err_exp;
    ram_frame_row_buf dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .init_done_o(init_done_o),
        .cena_i(cena_i), .wena_i(wena_i), .bea_i(bea_i), .addra_i(addra_i), .dataa_i(dataa_i),
        .cenb_i(cenb_i), .addrb_i(addrb_i), .datab_o(datab_o), .datab_vld_o(datab_vld_o),
        .addr_err_o(addr_err_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic model_clear();
        foreach (mdl[a]) mdl[a] = 32'h0;
    endtask
    task automatic reset_chk();
        chk("rst_datab", datab_o, 32'h0);
        chk("rst_vld", datab_vld_o, 32'h0);
        chk("rst_init_done", init_done_o, 32'h0);
        chk("rst_addr_err", addr_err_o, 32'h0);
    endtask
    // one clock: drive, predict, step, compare
    task automatic cyc(input bit rd, input logic [8:0] ab, input bit wr, input logic [8:0] aa,
                       input logic [31:0] da, input logic [3:0] be, input bit clr);
        logic [31:0] e;
        bit rdy;
        rdy = (left == 0);
        cenb_i = !rd; addrb_i = ab; cena_i = !wr; wena_i = !wr;
        addra_i = aa; dataa_i = da; bea_i = be; clr_i = clr;
        if (rdy && rd) begin
            e = 32'h0;
            if (ab < 480) begin
                e = mdl[ab];
                if (wr && aa == ab)
                    for (int k = 0; k < 4; k++) if (be[k]) e[8*k +: 8] = da[8*k +: 8];
            end
            exp_q.push_back(e);
        end
        if (rdy && wr && aa < 480)
            for (int k = 0; k < 4; k++) if (be[k]) mdl[aa][8*k +: 8] = da[8*k +: 8];
        if (rdy && ((wr && aa >= 480) || (rd && ab >= 480))) err_exp = 1'b1;
        if (clr) begin
            err_exp = 1'b0;
            left = 480;
            model_clear();
        end else if (!rdy) begin
            left--;
        end
        @(posedge clk);
        #1;
        if (rdy && rd) begin
            e = exp_q.pop_front();
            chk("rd_data", datab_o, e);
            chk("rd_vld", datab_vld_o, 32'h1);
            last_d = e;
        end else begin
            chk("idle_vld", datab_vld_o, 32'h0);
            chk("hold_data", datab_o, last_d);
        end
        chk("init_done", init_done_o, 32'(left == 0));
        chk("addr_err", addr_err_o, 32'(err_exp));
        cena_i = 1'b1; wena_i = 1'b1; cenb_i = 1'b1; clr_i = 1'b0;
    endtask
    task automatic idle();
        cyc(0, 9'd0, 0, 9'd0, 32'h0, 4'h0, 0);
    endtask
    task automatic rd(input logic [8:0] a);
        cyc(1, a, 0, 9'd0, 32'h0, 4'h0, 0);
    endtask
    task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(0, 9'd0, 1, a, d, be, 0);
    endtask
    initial begin
        rst_n = 1'b0; clr_i = 1'b0; cena_i = 1'b1; wena_i = 1'b1; cenb_i = 1'b1;
        bea_i = 4'h0; addra_i = '0; dataa_i = '0; addrb_i = '0;
        last_d = 32'h0; err_exp = 1'b0; left = 480;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset_chk();
        rst_n = 1'b1;
        // initial clear: reads during INIT must be dropped
        for (int n = 0; n < 480; n++) if (n % 97 == 0) rd(9'(n)); else idle();
        rd(9'd0); rd(9'd239); rd(9'd479);
        wr(9'd5, 32'hAABBCCDD, 4'b1111);
        wr(9'd5, 32'h11223344, 4'b0101);
        rd(9'd5);
        wr(9'd17, 32'h01020304, 4'b1111);
        cyc(1, 9'd17, 1, 9'd17, 32'hDEADBEEF, 4'b1100, 0);
        idle();
        rd(9'd17);
        wr(9'd6, 32'h12345678, 4'b0000);
        cyc(0, 9'd0, 0, 9'd0, 32'h0, 4'h0, 0);
        rd(9'd6);
        cyc(1, 9'd480, 1, 9'd500, 32'h55555555, 4'hF, 0);
        idle(); idle();
        rd(9'd511);
        cyc(0, 9'd0, 0, 9'd0, 32'h0, 4'h0, 1);
        for (int n = 0; n < 480; n++) idle();
        for (int a = 0; a < 480; a++) wr(9'(a), 32'(a), 4'hF);
        for (int a = 0; a < 480; a++) rd(9'(a));
        cyc(1, 9'd479, 0, 9'd0, 32'h0, 4'h0, 1);
        for (int n = 0; n < 480; n++) rd(9'(n));
        for (int a = 0; a < 480; a++) rd(9'(a));
        // reset mid-INIT at clear count 100, with a read pending
        wr(9'd3, 32'hCAFEF00D, 4'hF);
        cyc(0, 9'd0, 0, 9'd0, 32'h0, 4'h0, 1);
        for (int n = 0; n < 100; n++) idle();
        cenb_i = 1'b0; addrb_i = 9'd3;
        rst_n = 1'b0;
        #1;
        reset_chk();
        repeat (2) begin
            @(posedge clk);
            #1;
            reset_chk();
        end
        cenb_i = 1'b1;
        rst_n = 1'b1;
        left = 480; err_exp = 1'b0; last_d = 32'h0;
        model_clear();
        for (int n = 0; n < 480; n++) idle();
        rd(9'd3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
